vote_collector: RTL and testbench
=================================

Name: vote_collector

Overview:
- Front end that feeds the voting logic: opens a voting round and collects one ballot bit per voter over a valid/ready handshake.
- Closes the round when every voter has voted or when a timeout expires.
- Registers the assembled ballot vector and produces a one-cycle result strobe with winner (strict majority) and tie (exactly half) flags.

Parameters:
- N_VOTERS, 4, number of voters; must be ≥2.
- ID_W, 2, voter-ID width; must equal ceil(log2(N_VOTERS)).
- TIMEOUT, 16, number of cycles spent in COLLECT before the round is force-closed; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  opens a round; sampled only in IDLE.
- vote_valid  in  1  a ballot is presented this cycle.
- vote_id  in  ID_W  index of the voter presenting the ballot.
- vote_val  in  1  1 = yes, 0 = no.
- vote_ready  out  1  collector is accepting ballots.
- busy  out  1  high in COLLECT and RESULT.
- ballot  out  N_VOTERS  recorded votes; absent voters read as 0.
- voted  out  N_VOTERS  mask of voters whose ballot was recorded this round.
- dup_err  out  1  one-cycle pulse when a second ballot from an already-voted ID is presented.
- result_valid  out  1  one-cycle pulse when the round closes.
- win  out  1  popcount(ballot) > N_VOTERS/2 (integer division).
- tie  out  1  2·popcount(ballot) == N_VOTERS; always 0 for odd N_VOTERS.
- timed_out  out  1  round closed by timeout rather than full participation.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0: ballot, voted, win, tie, timed_out, dup_err, result_valid, vote_ready, busy.
  - Timer = 0.
- IDLE:
  - vote_ready = 0.
  - vote_valid is ignored; no dup_err is raised.
  - On start = 1, the next edge moves to COLLECT and clears ballot, voted, win, tie, timed_out and the timer.
  - ballot, win, tie and timed_out from the previous round hold until this clear.
- COLLECT:
  - vote_ready = 1 combinationally from state.
  - A transfer is a cycle with vote_valid & vote_ready.
  - New voter (voted[vote_id] = 0): on that edge, ballot[vote_id] <= vote_val and voted[vote_id] <= 1.
  - Already-voted voter: the ballot is ignored (first vote stands) and dup_err pulses high the next cycle for one cycle.
  - vote_id ≥ N_VOTERS (non-power-of-2 N) is ignored and raises dup_err.
  - start is ignored in COLLECT.
  - The timer counts cycles in COLLECT; the first COLLECT cycle is count 0.
- Close conditions, evaluated on each COLLECT edge including that cycle's transfer:
  - All voted: go to RESULT, timed_out <= 0.
  - Otherwise, timer == TIMEOUT-1: go to RESULT, timed_out <= 1.
  - A transfer on the timeout cycle is recorded. If it completes the mask, the round closes with timed_out = 0 (full participation wins the tie-break).
- RESULT (exactly one cycle):
  - result_valid = 1 and busy = 1.
  - win and tie are registered on entry from the final ballot; missing voters count as no.
  - Next edge returns to IDLE.
  - start in RESULT is ignored.
- Latency:
  - Final accepted ballot in cycle k gives result_valid in cycle k+1.
  - Timeout gives result_valid in COLLECT cycle TIMEOUT.
  - The fastest round (start sampled at cycle 0, votes every cycle) gives result_valid at cycle N_VOTERS+1.
- Result flags: win and tie are mutually exclusive; both are 0 when popcount < N_VOTERS/2.
- Reset mid-round: aborts immediately. No result_valid is produced and all registers return to reset values.

Test Plan:
- Full yes round: start; votes (id 0..3) = 1,1,1,0 on consecutive cycles → result_valid one cycle after the 4th transfer; ballot = 4'b0111, win = 1, tie = 0, timed_out = 0.
- Tie, out-of-order IDs: votes id3 = 1, id0 = 0, id2 = 1, id1 = 0 → ballot = 4'b1100, tie = 1, win = 0; vote_ready low in IDLE after the result.
- Duplicate: id1 = 1, then id1 = 0 again, then id0 = 0, id2 = 0, id3 = 0 → dup_err pulses once, ballot[1] stays 1; ballot = 4'b0010, win = 0, tie = 0.
- Timeout: TIMEOUT = 16; only id0 = 1 and id2 = 1 arrive → result_valid in COLLECT cycle 16; timed_out = 1, ballot = 4'b0101, tie = 1.
- Completion on the timeout cycle: id0..id2 = 1 early, id3 = 1 presented in COLLECT cycle 15 → timed_out = 0, ballot = 4'b1111, win = 1.
- Reset and ignore checks:
  - Drop rst_n after 2 ballots → outputs return to 0 asynchronously, with no result_valid.
  - Pulse start during COLLECT → no effect on ballot or timer.

Source files
------------

// File: rtl/vote_collector.sv
`default_nettype none
// ==========================================================================
// vote_collector : gathers one ballot bit per voter, closes on full mask/timeout
// Revision       : 1.0
// ==========================================================================
module vote_collector #(
  parameter int N_VOTERS = 4,
  parameter int ID_W     = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                vote_valid,
  input  logic [ID_W-1:0]     vote_id,
  input  logic                vote_val,
  output logic                vote_ready,
  output logic                busy,
  output logic [N_VOTERS-1:0] ballot,
  output logic [N_VOTERS-1:0] voted,
  output logic                dup_err,
  output logic                result_valid,
  output logic                win,
  output logic                tie,
  output logic                timed_out
);

  localparam int c_timer_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int c_cnt_w   = $clog2(N_VOTERS + 1);
  localparam logic [ID_W:0]        c_n_ext     = (ID_W + 1)'(N_VOTERS);
  localparam logic [c_timer_w-1:0] c_timer_end = c_timer_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESULT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [N_VOTERS-1:0]   ballot_q, ballot_d;
  logic [N_VOTERS-1:0]   voted_q, voted_d;
  logic [c_timer_w-1:0]  timer_q, timer_d;
  logic                  dup_err_q, dup_err_d;
  logic                  win_q, win_d;
  logic                  tie_q, tie_d;
  logic                  timed_out_q, timed_out_d;

  logic [N_VOTERS-1:0]   w_sel;
  logic [N_VOTERS-1:0]   w_ballot_nx;
  logic [N_VOTERS-1:0]   w_voted_nx;
  logic [c_cnt_w-1:0]    w_cnt;
  logic                  w_xfer;
  logic                  w_id_ok;
  logic                  w_accept;
  logic                  w_win;
  logic                  w_tie;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      w_sel[i] = (vote_id == ID_W'(i));
    end

    w_xfer   = vote_valid & (state_q == ST_COLLECT);
    w_id_ok  = ({1'b0, vote_id} < c_n_ext);
    w_accept = w_xfer & w_id_ok & ~(|(w_sel & voted_q));

    // Ballot and mask as they will stand after this cycle's transfer
    w_ballot_nx = w_accept ? ((ballot_q & ~w_sel) | (w_sel & {N_VOTERS{vote_val}}))
                           : ballot_q;
    w_voted_nx  = w_accept ? (voted_q | w_sel) : voted_q;

    w_cnt = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      w_cnt = w_cnt + c_cnt_w'(w_ballot_nx[i]);
    end
    w_win = (w_cnt > c_cnt_w'(N_VOTERS / 2));
    w_tie = ({w_cnt, 1'b0} == (c_cnt_w + 1)'(N_VOTERS));

    state_d     = state_q;
    ballot_d    = ballot_q;
    voted_d     = voted_q;
    timer_d     = timer_q;
    dup_err_d   = 1'b0;
    win_d       = win_q;
    tie_d       = tie_q;
    timed_out_d = timed_out_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_COLLECT;
          ballot_d    = '0;
          voted_d     = '0;
          timer_d     = '0;
          win_d       = 1'b0;
          tie_d       = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        ballot_d  = w_ballot_nx;
        voted_d   = w_voted_nx;
        dup_err_d = w_xfer & ~w_accept;
        // Full participation takes priority over an expiring timer
        if (&w_voted_nx) begin
          state_d     = ST_RESULT;
          timed_out_d = 1'b0;
          win_d       = w_win;
          tie_d       = w_tie;
        end else if (timer_q == c_timer_end) begin
          state_d     = ST_RESULT;
          timed_out_d = 1'b1;
          win_d       = w_win;
          tie_d       = w_tie;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ballot_q    <= '0;
      voted_q     <= '0;
      timer_q     <= '0;
      dup_err_q   <= 1'b0;
      win_q       <= 1'b0;
      tie_q       <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ballot_q    <= ballot_d;
      voted_q     <= voted_d;
      timer_q     <= timer_d;
      dup_err_q   <= dup_err_d;
      win_q       <= win_d;
      tie_q       <= tie_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign vote_ready   = (state_q == ST_COLLECT);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_RESULT);
  assign ballot       = ballot_q;
  assign voted        = voted_q;
  assign dup_err      = dup_err_q;
  assign win          = win_q;
  assign tie          = tie_q;
  assign timed_out    = timed_out_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_collector.sv
`default_nettype none
// ==========================================================================
// tb_vote_collector : directed rounds plus random traffic against a ballot model
// Revision          : 1.0
// ==========================================================================
module tb_vote_collector;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           vote_valid = 1'b0;
  logic [IDW-1:0] vote_id = '0;
  logic           vote_val = 1'b0;
  logic           vote_ready, busy, dup_err, result_valid, win, tie, timed_out;
  logic [N-1:0]   ballot, voted;

  vote_collector #(.N_VOTERS(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid),
    .vote_id(vote_id), .vote_val(vote_val), .vote_ready(vote_ready),
    .busy(busy), .ballot(ballot), .voted(voted), .dup_err(dup_err),
    .result_valid(result_valid), .win(win), .tie(tie), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dup_cnt = 0;
  int rv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Round model: 0 = no round open, 1 = collecting, 2 = result cycle
  int         m_phase;
  int         m_t;
  logic [N-1:0] m_ballot, m_voted;
  logic       m_win, m_tie, m_to, m_dup;

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_ballot = '0; m_voted = '0;
    m_win = 0; m_tie = 0; m_to = 0; m_dup = 0;
  endtask

  task automatic model_close(input logic by_timeout);
    int yes;
    yes     = $countones(m_ballot);
    m_win   = (yes > N / 2);
    m_tie   = (2 * yes == N);
    m_to    = by_timeout;
    m_phase = 2;
  endtask

  task automatic model_step();
    logic d;
    d = 1'b0;
    case (m_phase)
      0: if (start) begin
        m_ballot = '0; m_voted = '0; m_win = 0; m_tie = 0; m_to = 0;
        m_t = 0; m_phase = 1;
      end
      1: begin
        if (vote_valid) begin
          if (int'(vote_id) >= N || m_voted[vote_id]) d = 1'b1;
          else begin
            m_ballot[vote_id] = vote_val;
            m_voted[vote_id]  = 1'b1;
          end
        end
        if (m_voted == '1) model_close(1'b0);
        else if (m_t == TO - 1) model_close(1'b1);
        else m_t++;
      end
      default: m_phase = 0;
    endcase
    m_dup = d;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (dup_err === 1'b1) dup_cnt++;
      if (result_valid === 1'b1) rv_cnt++;
      check("cmp_vote_ready", 32'(vote_ready), 32'(m_phase == 1));
      check("cmp_busy", 32'(busy), 32'(m_phase != 0));
      check("cmp_result_valid", 32'(result_valid), 32'(m_phase == 2));
      check("cmp_ballot", 32'(ballot), 32'(m_ballot));
      check("cmp_voted", 32'(voted), 32'(m_voted));
      check("cmp_dup_err", 32'(dup_err), 32'(m_dup));
      check("cmp_win", 32'(win), 32'(m_win));
      check("cmp_tie", 32'(tie), 32'(m_tie));
      check("cmp_timed_out", 32'(timed_out), 32'(m_to));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int id, input logic val);
    vote_valid = 1'b1;
    vote_id    = IDW'(id);
    vote_val   = val;
    @(negedge clk);
    vote_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int k = 0; k < 40 && result_valid !== 1'b1; k++) @(negedge clk);
    check({name, "_result_valid"}, 32'(result_valid), 32'd1);
  endtask

  initial begin
    int t0, d0, r0, p;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(vote_ready), 32'd0);
    check("reset_ballot", 32'(ballot), 32'd0);
    check("reset_rv", 32'(result_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full round, consecutive IDs
    do_start(); t0 = cyc;
    send(0, 1); send(1, 1); send(2, 1); send(3, 0);
    wait_result("full");
    check("full_latency", 32'(cyc - t0), 32'd4);
    check("full_ballot", 32'(ballot), 32'b0111);
    check("full_win", 32'(win), 32'd1);
    check("full_tie", 32'(tie), 32'd0);
    check("full_to", 32'(timed_out), 32'd0);
    @(negedge clk);

    // Tie with out-of-order IDs
    do_start();
    send(3, 1); send(0, 0); send(2, 1); send(1, 0);
    wait_result("tie");
    check("tie_ballot", 32'(ballot), 32'b1100);
    check("tie_tie", 32'(tie), 32'd1);
    check("tie_win", 32'(win), 32'd0);
    @(negedge clk);
    check("tie_idle_ready", 32'(vote_ready), 32'd0);

    // Duplicate ballot: first vote stands
    d0 = dup_cnt;
    do_start();
    send(1, 1); send(1, 0); send(0, 0); send(2, 0); send(3, 0);
    wait_result("dup");
    check("dup_pulses", 32'(dup_cnt - d0), 32'd1);
    check("dup_ballot", 32'(ballot), 32'b0010);
    check("dup_win", 32'(win), 32'd0);
    check("dup_tie", 32'(tie), 32'd0);
    @(negedge clk);

    // Timeout with two voters
    do_start(); t0 = cyc;
    send(0, 1); send(2, 1);
    wait_result("tmo");
    check("tmo_latency", 32'(cyc - t0), 32'd16);
    check("tmo_to", 32'(timed_out), 32'd1);
    check("tmo_ballot", 32'(ballot), 32'b0101);
    check("tmo_tie", 32'(tie), 32'd1);
    @(negedge clk);

    // Last voter arrives in the final COLLECT cycle
    do_start(); t0 = cyc;
    send(0, 1); send(1, 1); send(2, 1);
    repeat (12) @(negedge clk);
    send(3, 1);
    wait_result("edge");
    check("edge_latency", 32'(cyc - t0), 32'd16);
    check("edge_to", 32'(timed_out), 32'd0);
    check("edge_ballot", 32'(ballot), 32'b1111);
    check("edge_win", 32'(win), 32'd1);
    @(negedge clk);

    // start during COLLECT must not restart the round or the timer
    do_start(); t0 = cyc;
    send(0, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_result("restart");
    check("restart_latency", 32'(cyc - t0), 32'd16);
    check("restart_ballot", 32'(ballot), 32'b0001);
    check("restart_to", 32'(timed_out), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-round
    do_start();
    send(0, 1); send(1, 1);
    r0 = rv_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("areset_ballot", 32'(ballot), 32'd0);
    check("areset_voted", 32'(voted), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_ready", 32'(vote_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("areset_no_result", 32'(rv_cnt - r0), 32'd0);
    check("areset_idle", 32'(busy), 32'd0);

    // Random traffic with varying ballot density and rare resets
    p = 5;
    for (int i = 0; i < 1200; i++) begin
      if (i % 60 == 0) p = $urandom_range(1, 10);
      start      = ($urandom_range(0, 9) == 0);
      vote_valid = ($urandom_range(0, 9) < p);
      vote_id    = IDW'($urandom_range(0, N - 1));
      vote_val   = 1'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start = 1'b0; vote_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
